// File: rtl/out_port_fifo.sv
// out_port_fifo
//   Buffered multi-channel output port. Each out_in strobe captures
//   {ch_sel, bus_data} into a DEPTH-entry FIFO. The head entry is offered to
//   devices over a valid/ready handshake.
//
//   Optional build macro: OUT_PORT_HOLD_EN
//     defined   : the last popped entry is held and shown while the FIFO is empty
//     undefined : dev_data/dev_ch read 0 while the FIFO is empty
//
// Ports
//   Clock      in   system clock, rising edge
//   clear      in   synchronous active-high reset, dominant over all inputs
//   out_in     in   push strobe
//   ch_sel     in   channel tag stored with the data
//   bus_data   in   data word to store
//   ovf_clr    in   clears the sticky overflow flag
//   dev_valid  out  head entry available
//   dev_ready  in   device accepts the head entry
//   dev_data   out  head data
//   dev_ch     out  head channel tag
//   full       out  count == DEPTH
//   empty      out  count == 0
//   count      out  occupied entries, 0..DEPTH
//   overflow   out  sticky: a push was dropped
module out_port_fifo #(
    parameter  int unsigned DATA_W = 32,
    parameter  int unsigned DEPTH  = 4,
    parameter  int unsigned CH_W   = 1,
    localparam int unsigned PTR_W  = $clog2(DEPTH),
    localparam int unsigned CNT_W  = PTR_W + 1
) (
    input  logic              Clock,
    input  logic              clear,
    input  logic              out_in,
    input  logic [CH_W-1:0]   ch_sel,
    input  logic [DATA_W-1:0] bus_data,
    input  logic              ovf_clr,
    output logic              dev_valid,
    input  logic              dev_ready,
    output logic [DATA_W-1:0] dev_data,
    output logic [CH_W-1:0]   dev_ch,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
);

    localparam int unsigned ENT_W = CH_W + DATA_W;

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;

    logic             is_empty, is_full;
    logic             pop, push, drop;
    logic [ENT_W-1:0] head;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CNT_W'(DEPTH));

    // A pop frees the slot a same-edge push needs, so a full FIFO still
    // accepts a push when the head is leaving on that edge.
    assign pop  = !is_empty && dev_ready;
    assign push = out_in && (!is_full || pop);
    assign drop = out_in && is_full && !pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop)
            count_d = count_q + CNT_W'(1);
        else if (pop && !push)
            count_d = count_q - CNT_W'(1);
        // A drop on the same edge as ovf_clr keeps the flag set.
        if (drop)
            ovf_d = 1'b1;
        else if (ovf_clr)
            ovf_d = 1'b0;
    end

    always_ff @(posedge Clock) begin
        if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is not reset; only pointers and count define validity.
    always_ff @(posedge Clock) begin
        if (!clear && push)
            mem_q[wr_ptr_q] <= {ch_sel, bus_data};
    end

    assign head = mem_q[rd_ptr_q];

`ifdef OUT_PORT_HOLD_EN
    logic [ENT_W-1:0] hold_q;

    always_ff @(posedge Clock) begin
        if (clear)
            hold_q <= '0;
        else if (pop)
            hold_q <= head;
    end

    assign {dev_ch, dev_data} = is_empty ? hold_q : head;
`else
    assign {dev_ch, dev_data} = is_empty ? '0 : head;
`endif

    assign dev_valid = !is_empty;
    assign full      = is_full;
    assign empty     = is_empty;
    assign count     = count_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_out_port_fifo.sv
module tb_out_port_fifo;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int CH_W   = 1;
    localparam int CNT_W  = 3;
    localparam int ENT_W  = CH_W + DATA_W;
    localparam int OBS_W  = 4 + CNT_W + CH_W + DATA_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              clear, out_in, ovf_clr, dev_ready;
    logic [CH_W-1:0]   ch_sel;
    logic [DATA_W-1:0] bus_data;
    logic              dev_valid, full, empty, overflow;
    logic [DATA_W-1:0] dev_data;
    logic [CH_W-1:0]   dev_ch;
    logic [CNT_W-1:0]  count;

    out_port_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CH_W(CH_W)) dut (
        .Clock(clk), .clear(clear), .out_in(out_in), .ch_sel(ch_sel),
        .bus_data(bus_data), .ovf_clr(ovf_clr), .dev_valid(dev_valid),
        .dev_ready(dev_ready), .dev_data(dev_data), .dev_ch(dev_ch),
        .full(full), .empty(empty), .count(count), .overflow(overflow)
    );

    wire [OBS_W-1:0] obs = {dev_valid, full, empty, count, overflow, dev_ch, dev_data};

    int checks = 0;
    int errors = 0;

    // Reference model: a queue of entries plus overflow flag and last popped entry.
    logic [ENT_W-1:0] mq[$];
    logic             m_ovf  = 1'b0;
    logic [ENT_W-1:0] m_hold = '0;

    function automatic logic [OBS_W-1:0] exp_obs();
        logic [ENT_W-1:0] hd;
        int n;
        n = mq.size();
        if (n > 0) hd = mq[0];
        else begin
`ifdef OUT_PORT_HOLD_EN
            hd = m_hold;
`else
            hd = '0;
`endif
        end
        return {n > 0, n == DEPTH, n == 0, CNT_W'(n), m_ovf, hd};
    endfunction

    function automatic logic [DATA_W-1:0] exp_idle_data(input logic [DATA_W-1:0] last);
`ifdef OUT_PORT_HOLD_EN
        return last;
`else
        return '0;
`endif
    endfunction

    // One clock edge; model applies the inputs that were sampled on it.
    task automatic tick();
        bit pop, accepted;
        @(posedge clk);
        #1;
        if (clear) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_hold = '0;
        end else begin
            pop = (mq.size() > 0) && dev_ready;
            if (pop) m_hold = mq.pop_front();
            accepted = 1'b0;
            if (out_in && mq.size() < DEPTH) begin
                mq.push_back({ch_sel, bus_data});
                accepted = 1'b1;
            end
            if (out_in && !accepted) m_ovf = 1'b1;
            else if (ovf_clr)        m_ovf = 1'b0;
        end
    endtask

    task automatic idle();
        clear = 0; out_in = 0; ovf_clr = 0; dev_ready = 0;
    endtask

    task automatic test_reset();
        clear = 1; out_in = 1; ch_sel = 1; bus_data = 32'hDEAD_BEEF; dev_ready = 0; ovf_clr = 0;
        repeat (2) tick();
        idle();
        checks++;
        if (obs !== exp_obs()) begin errors++; $display("FAIL reset_model obs=%h exp=%h", obs, exp_obs()); end
        checks++;
        if ({dev_valid, empty, count, overflow, dev_data} !== {1'b0, 1'b1, 3'd0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset_values valid=%b empty=%b count=%0d ovf=%b data=%h exp 0 1 0 0 0",
                     dev_valid, empty, count, overflow, dev_data);
        end
    endtask

    task automatic test_single_push();
        out_in = 1; ch_sel = 1; bus_data = 32'h12; dev_ready = 0;
        tick();
        out_in = 0;
        checks++;
        if ({dev_valid, dev_data, dev_ch, count} !== {1'b1, 32'h12, 1'b1, 3'd1}) begin
            errors++;
            $display("FAIL single_push valid=%b data=%h ch=%b count=%0d exp 1 12 1 1",
                     dev_valid, dev_data, dev_ch, count);
        end
        dev_ready = 1;
        tick();
        dev_ready = 0;
        checks++;
        if ({empty, count, dev_data} !== {1'b1, 3'd0, exp_idle_data(32'h12)}) begin
            errors++;
            $display("FAIL single_pop empty=%b count=%0d data=%h exp 1 0 %h",
                     empty, count, dev_data, exp_idle_data(32'h12));
        end
    endtask

    task automatic test_fill_overflow();
        ch_sel = 0;
        for (int v = 1; v <= 5; v++) begin
            out_in = 1; bus_data = v;
            tick();
        end
        out_in = 0;
        checks++;
        if ({full, count, overflow} !== {1'b1, 3'd4, 1'b1}) begin
            errors++;
            $display("FAIL fill_ovf full=%b count=%0d ovf=%b exp 1 4 1", full, count, overflow);
        end
        dev_ready = 1;
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (dev_valid !== 1'b1 || dev_data !== 32'(i)) begin
                errors++;
                $display("FAIL drain_order valid=%b data=%0d exp 1 %0d", dev_valid, dev_data, i);
            end
            tick();
        end
        dev_ready = 0;
        checks++;
        if ({empty, overflow} !== 2'b11) begin
            errors++;
            $display("FAIL drain_end empty=%b ovf=%b exp 1 1", empty, overflow);
        end
        ovf_clr = 1;
        tick();
        ovf_clr = 0;
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr ovf=%b exp 0", overflow); end
    endtask

    task automatic test_full_push_pop();
        int expv[4] = '{2, 3, 4, 9};
        for (int v = 1; v <= 4; v++) begin
            out_in = 1; bus_data = v;
            tick();
        end
        out_in = 1; bus_data = 9; dev_ready = 1;
        tick();
        out_in = 0;
        checks++;
        if ({count, overflow, full} !== {3'd4, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL full_pushpop count=%0d ovf=%b full=%b exp 4 0 1", count, overflow, full);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dev_valid !== 1'b1 || dev_data !== 32'(expv[i])) begin
                errors++;
                $display("FAIL full_pushpop_order valid=%b data=%0d exp 1 %0d", dev_valid, dev_data, expv[i]);
            end
            tick();
        end
        dev_ready = 0;
        checks++;
        if (obs !== exp_obs()) begin errors++; $display("FAIL full_pushpop_end obs=%h exp=%h", obs, exp_obs()); end
    endtask

    task automatic test_wrap_stream();
        dev_ready = 1; ch_sel = 0;
        for (int i = 0; i < 10; i++) begin
            out_in = 1; bus_data = 100 + i;
            tick();
            checks++;
            if (dev_valid !== 1'b1 || dev_data !== 32'(100 + i) || count !== 3'd1) begin
                errors++;
                $display("FAIL wrap_stream valid=%b data=%0d count=%0d exp 1 %0d 1",
                         dev_valid, dev_data, count, 100 + i);
            end
        end
        out_in = 0;
        tick();
        dev_ready = 0;
        checks++;
        if (obs !== exp_obs() || empty !== 1'b1) begin
            errors++;
            $display("FAIL wrap_end obs=%h exp=%h", obs, exp_obs());
        end
    endtask

    task automatic test_reset_mid();
        for (int v = 0; v < 3; v++) begin
            out_in = 1; bus_data = 32'hA0 + v;
            tick();
        end
        out_in = 0;
        checks++;
        if ({dev_valid, count} !== {1'b1, 3'd3}) begin
            errors++;
            $display("FAIL mid_fill valid=%b count=%0d exp 1 3", dev_valid, count);
        end
        clear = 1; out_in = 1; bus_data = 32'h5555;
        tick();
        clear = 0; out_in = 0;
        checks++;
        if ({dev_valid, count} !== {1'b0, 3'd0}) begin
            errors++;
            $display("FAIL mid_clear valid=%b count=%0d exp 0 0", dev_valid, count);
        end
        tick();
        checks++;
        if ({dev_valid, count, dev_data} !== {1'b0, 3'd0, 32'h0}) begin
            errors++;
            $display("FAIL mid_not_stored valid=%b count=%0d data=%h exp 0 0 0", dev_valid, count, dev_data);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            clear     = ($urandom_range(0, 49) == 0);
            out_in    = ($urandom_range(0, 99) < 60);
            dev_ready = ($urandom_range(0, 99) < 45);
            ovf_clr   = ($urandom_range(0, 19) == 0);
            ch_sel    = CH_W'($urandom);
            bus_data  = $urandom;
            tick();
            checks++;
            if (obs !== exp_obs()) begin
                errors++;
                $display("FAIL random cyc=%0d obs=%h exp=%h", i, obs, exp_obs());
            end
        end
        idle();
    endtask

    initial begin
        idle();
        ch_sel = 0; bus_data = 0;
        test_reset();
        test_single_push();
        test_fill_overflow();
        test_full_push_pop();
        test_wrap_stream();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/out_port_fifo.md
# out_port_fifo

Buffered, multi-channel output port for the simple CPU datapath, replacing the single-register OutPort. Each cycle the control unit asserts `out_in` for an `out` instruction, the block captures the bus word and a channel tag into a DEPTH-entry FIFO. The head entry is presented to external devices over a valid/ready handshake. Status flags (full, empty, count, sticky overflow) are available for the control unit and for software polling.

## Interface
Parameters:
- DATA_W, 32, width of bus data and device data
- DEPTH, 4, FIFO entries; power of two, at least 2
- CH_W, 1, channel-tag width; 2^CH_W logical output channels
- Derived: PTR_W = log2(DEPTH); CNT_W = PTR_W+1

Ports:
- Clock  in  1  system clock; all state updates on the rising edge
- clear  in  1  reset, synchronous, active-high
- out_in  in  1  push strobe from the control unit; one push per cycle held high
- ch_sel  in  CH_W  channel tag captured with the data
- bus_data  in  DATA_W  datapath bus word to capture
- ovf_clr  in  1  clears the sticky overflow flag
- dev_valid  out  1  head entry available
- dev_ready  in  1  device accepts head entry
- dev_data  out  DATA_W  head data
- dev_ch  out  CH_W  head channel tag
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- count  out  CNT_W  occupied entries, 0..DEPTH
- overflow  out  1  sticky: a push was dropped

## Operation
- Storage: DEPTH x (DATA_W+CH_W) array, write pointer wr_ptr, read pointer rd_ptr (PTR_W bits, wrap modulo DEPTH), count register.
- Push: out_in=1 at an edge writes {ch_sel, bus_data} at wr_ptr and increments wr_ptr.
- Pop: dev_valid & dev_ready at an edge increments rd_ptr.
- Push accepted when count<DEPTH, or when count==DEPTH and a pop occurs on the same edge (count unchanged).
- Push when full without a same-edge pop: data dropped, pointers and count unchanged, overflow set to 1.
- Simultaneous push and pop when not full and not empty: both occur, count unchanged.
- Push while empty: no bypass. The entry becomes visible the following cycle.
- count: +1 on push only, -1 on pop only, unchanged otherwise.
- dev_valid = !empty. dev_data/dev_ch = array[rd_ptr] while not empty.
- dev_ready is ignored while empty.
- overflow: set by a dropped push, cleared by ovf_clr. If both occur on the same edge, set wins.
- clear: synchronous and dominant over every other input on that edge. Pointers=0, count=0, overflow=0.
- Array contents are not cleared by `clear`. An in-progress handshake is abandoned and the entry is lost.

## Timing
- Reset values, on the edge `clear` is sampled high: dev_valid=0, dev_data=0, dev_ch=0, full=0, empty=1, count=0, overflow=0.
- Push-to-visible latency: out_in high at edge N gives dev_valid=1 and dev_data valid after edge N.
- Throughput: one push and one pop per cycle sustained.
- full, empty, count and overflow are registered or derived from registered state. They are valid immediately after each edge.
- dev_data/dev_ch are stable while dev_valid=1 and dev_ready=0. The device may hold dev_ready high indefinitely.
- Wrap-around: a pointer at DEPTH-1 goes to 0 on the next increment. No bubble.

## Configuration
- OUT_PORT_HOLD_EN defined: a DATA_W+CH_W hold register captures the head on every pop. While empty, dev_data/dev_ch show the last popped value, giving legacy OutPort-style persistent display. The hold register is reset to 0 by `clear`.
- OUT_PORT_HOLD_EN undefined: dev_data and dev_ch are forced to 0 while empty.

## Test plan
- Reset: clear=1 for 2 cycles with out_in=1 and bus_data=32'hDEAD_BEEF -> count=0, empty=1, dev_valid=0, dev_data=0, overflow=0.
- Single push: out_in=1, ch_sel=1, bus_data=32'h0000_0012 for one cycle, dev_ready=0 -> next cycle dev_valid=1, dev_data=32'h12, dev_ch=1, count=1. Then dev_ready=1 for one cycle -> empty=1, count=0. With OUT_PORT_HOLD_EN, dev_data stays 32'h12.
- Fill and overflow: 5 consecutive pushes of 1,2,3,4,5 with dev_ready=0 and DEPTH=4 -> full=1, count=4, overflow=1. Draining then yields exactly 1,2,3,4 in order. ovf_clr=1 for one cycle -> overflow=0.
- Full with simultaneous push/pop: FIFO holds 1,2,3,4; out_in=1, bus_data=9, dev_ready=1 on the same edge -> count stays 4. Drain order is 2,3,4,9. overflow stays 0.
- Wrap-around streaming: dev_ready=1, 10 back-to-back pushes of 100..109 -> each value appears one cycle after its push. count never exceeds 1. Pointers wrap twice with no loss.
- Reset mid-operation: FIFO holds 3 entries with dev_valid=1, then clear=1 for one cycle with out_in=1 -> count=0, dev_valid=0. The pushed word is not stored.
